// File: rtl/avalon_rw8_arbiter_pkg.sv
// Shared encodings for the two-master RW8 Avalon arbiter and its grant logic.
package avalon_rw8_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam logic [7:0] TO_DATA_DEFAULT = 8'hFF;

endpackage

// File: rtl/avalon_rr_arb2.sv
// Two-request round-robin grant. The grant is combinational; the last-grant
// register only moves when the owner accepts the grant with load.
module avalon_rr_arb2
  import avalon_rw8_arbiter_pkg::*;
(
  input  logic csi_MCLK_clk,
  input  logic rsi_MRST_reset_n,
  input  logic req_a,
  input  logic req_b,
  input  logic load,
  output logic gnt_valid,
  output logic gnt_sel
);

  logic last_q;

  // Pick the port that did not win last time on a tie, else the lone requester.
  always_comb begin
    gnt_valid = req_a | req_b;
    gnt_sel   = PORT_A;
    if (req_a & req_b) begin
      gnt_sel = ~last_q;
    end else if (req_b) begin
      gnt_sel = PORT_B;
    end
  end

  // Remember the accepted grant; B at reset so A wins the first tie.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      last_q <= PORT_B;
    end else if (load & gnt_valid) begin
      last_q <= gnt_sel;
    end
  end

endmodule

// File: rtl/avalon_rw8_arbiter.sv
// Two-master to one-slave arbiter for 8-bit Avalon-MM register slaves.
// One transfer in flight; slave-side address/data/command are registered.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no transfer; arbitrate and latch the winner's request
// ST_ACCESS | command on the slave bus; wait for settle + waitrequest low
// ST_DONE   | one-cycle done pulse to the selected master, readdata valid
module avalon_rw8_arbiter
  import avalon_rw8_arbiter_pkg::*;
#(
  parameter int         SETTLE  = 2,
  parameter int         TIMEOUT = 64,
  parameter logic [7:0] TO_DATA = TO_DATA_DEFAULT
) (
  input  logic       csi_MCLK_clk,
  input  logic       rsi_MRST_reset_n,
  input  logic [5:0] avs_a_address,
  input  logic [7:0] avs_a_writedata,
  output logic [7:0] avs_a_readdata,
  input  logic       avs_a_write,
  input  logic       avs_a_read,
  output logic       avs_a_waitrequest,
  input  logic [5:0] avs_b_address,
  input  logic [7:0] avs_b_writedata,
  output logic [7:0] avs_b_readdata,
  input  logic       avs_b_write,
  input  logic       avs_b_read,
  output logic       avs_b_waitrequest,
  output logic [5:0] avm_address,
  output logic [7:0] avm_writedata,
  input  logic [7:0] avm_readdata,
  output logic       avm_write,
  output logic       avm_read,
  input  logic       avm_waitrequest,
  output logic       coe_timeout,
  input  logic       coe_timeout_clr
);

  // Slaves with a late-registered waitrequest look ready for SETTLE-1 cycles.
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);
  localparam logic [7:0] TO_SAT    = 8'(TIMEOUT);

  arb_state_t state_q, state_d;
  logic [7:0] cnt_q;
  logic       sel_q;
  logic       done_a_q, done_b_q;
  logic       req_a, req_b;
  logic       gnt_valid, gnt_sel;
  logic       grant, xfer_ok, xfer_to, finish;
  logic [7:0] rdata_cap;

  assign req_a = avs_a_read | avs_a_write;
  assign req_b = avs_b_read | avs_b_write;

  assign avs_a_waitrequest = req_a & ~done_a_q;
  assign avs_b_waitrequest = req_b & ~done_b_q;

  avalon_rr_arb2 u_arb (
    .csi_MCLK_clk     (csi_MCLK_clk),
    .rsi_MRST_reset_n (rsi_MRST_reset_n),
    .req_a            (req_a),
    .req_b            (req_b),
    .load             (grant),
    .gnt_valid        (gnt_valid),
    .gnt_sel          (gnt_sel)
  );

  // State register.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus grant / completion / timeout decode.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    xfer_ok = 1'b0;
    xfer_to = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          grant   = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        xfer_ok = (cnt_q >= SETTLE_M1) & ~avm_waitrequest;
        xfer_to = ~xfer_ok & (cnt_q == TO_LAST);
        if (xfer_ok | xfer_to) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign finish    = xfer_ok | xfer_to;
  assign rdata_cap = xfer_to ? TO_DATA : avm_readdata;

  // Slave-side request registers, access counter, done pulses and readdata.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      cnt_q          <= 8'd0;
      sel_q          <= PORT_A;
      avm_address    <= 6'd0;
      avm_writedata  <= 8'd0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      done_a_q       <= 1'b0;
      done_b_q       <= 1'b0;
      avs_a_readdata <= 8'd0;
      avs_b_readdata <= 8'd0;
    end else begin
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      if (grant) begin
        sel_q         <= gnt_sel;
        cnt_q         <= 8'd0;
        avm_address   <= (gnt_sel == PORT_B) ? avs_b_address : avs_a_address;
        avm_writedata <= (gnt_sel == PORT_B) ? avs_b_writedata : avs_a_writedata;
        // read wins when a master raises both commands
        avm_read      <= (gnt_sel == PORT_B) ? avs_b_read : avs_a_read;
        avm_write     <= (gnt_sel == PORT_B) ? (avs_b_write & ~avs_b_read)
                                             : (avs_a_write & ~avs_a_read);
      end else if ((state_q == ST_ACCESS) && (cnt_q != TO_SAT)) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (finish) begin
        avm_read  <= 1'b0;
        avm_write <= 1'b0;
        if (sel_q == PORT_B) begin
          done_b_q <= 1'b1;
          if (avm_read) avs_b_readdata <= rdata_cap;
        end else begin
          done_a_q <= 1'b1;
          if (avm_read) avs_a_readdata <= rdata_cap;
        end
      end
    end
  end

  // Sticky timeout flag; a new timeout beats a same-cycle clear.
  always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
    if (!rsi_MRST_reset_n) begin
      coe_timeout <= 1'b0;
    end else if (xfer_to) begin
      coe_timeout <= 1'b1;
    end else if (coe_timeout_clr) begin
      coe_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avalon_rw8_arbiter.sv
// Directed bench for avalon_rw8_arbiter with a small behavioural slave.
module tb_avalon_rw8_arbiter;

  logic       csi_MCLK_clk = 1'b0;
  logic       rsi_MRST_reset_n = 1'b0;
  logic [5:0] avs_a_address = '0;
  logic [7:0] avs_a_writedata = '0;
  logic [7:0] avs_a_readdata;
  logic       avs_a_write = 1'b0;
  logic       avs_a_read = 1'b0;
  logic       avs_a_waitrequest;
  logic [5:0] avs_b_address = '0;
  logic [7:0] avs_b_writedata = '0;
  logic [7:0] avs_b_readdata;
  logic       avs_b_write = 1'b0;
  logic       avs_b_read = 1'b0;
  logic       avs_b_waitrequest;
  logic [5:0] avm_address;
  logic [7:0] avm_writedata;
  logic [7:0] avm_readdata;
  logic       avm_write;
  logic       avm_read;
  logic       avm_waitrequest;
  logic       coe_timeout;
  logic       coe_timeout_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // slave model: mode 0 = waitrequest for wait_n command cycles,
  // mode 1 = ready on first command cycle then busy for wait_n cycles,
  // mode 2 = never ready
  int         slave_mode = 0;
  int         wait_n = 0;
  int         cmd_cnt = 0;
  bit         use_fixed = 1'b0;
  logic [7:0] fixed_rdata = 8'h00;

  always #5 csi_MCLK_clk = ~csi_MCLK_clk;

  always @(posedge csi_MCLK_clk) begin
    if (avm_read | avm_write) cmd_cnt <= cmd_cnt + 1;
    else cmd_cnt <= 0;
  end

  assign avm_waitrequest = (slave_mode == 2) ? 1'b1 :
                           (slave_mode == 1) ? ((cmd_cnt >= 1) && (cmd_cnt < 1 + wait_n)) :
                           (cmd_cnt < wait_n);
  assign avm_readdata = use_fixed ? fixed_rdata : ({2'b00, avm_address} ^ 8'hA0);

  avalon_rw8_arbiter dut (
    .csi_MCLK_clk      (csi_MCLK_clk),
    .rsi_MRST_reset_n  (rsi_MRST_reset_n),
    .avs_a_address     (avs_a_address),
    .avs_a_writedata   (avs_a_writedata),
    .avs_a_readdata    (avs_a_readdata),
    .avs_a_write       (avs_a_write),
    .avs_a_read        (avs_a_read),
    .avs_a_waitrequest (avs_a_waitrequest),
    .avs_b_address     (avs_b_address),
    .avs_b_writedata   (avs_b_writedata),
    .avs_b_readdata    (avs_b_readdata),
    .avs_b_write       (avs_b_write),
    .avs_b_read        (avs_b_read),
    .avs_b_waitrequest (avs_b_waitrequest),
    .avm_address       (avm_address),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .coe_timeout       (coe_timeout),
    .coe_timeout_clr   (coe_timeout_clr)
  );

  task automatic apply_reset();
    rsi_MRST_reset_n = 1'b0;
    avs_a_read = 0; avs_a_write = 0; avs_b_read = 0; avs_b_write = 0;
    coe_timeout_clr = 0;
    repeat (2) @(negedge csi_MCLK_clk);
    rsi_MRST_reset_n = 1'b1;
  endtask

  task automatic test_reset();
    rsi_MRST_reset_n = 1'b0;
    @(negedge csi_MCLK_clk);
    checks++;
    if ({avm_read, avm_write, avm_address, avm_writedata} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_avm: got rd=%b wr=%b addr=%h wd=%h want all 0", avm_read, avm_write, avm_address, avm_writedata);
    end
    checks++;
    if ({avs_a_readdata, avs_b_readdata} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_rdata: got a=%h b=%h want 00 00", avs_a_readdata, avs_b_readdata);
    end
    checks++;
    if ({avs_a_waitrequest, avs_b_waitrequest, coe_timeout} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got wa=%b wb=%b to=%b want 000", avs_a_waitrequest, avs_b_waitrequest, coe_timeout);
    end
    rsi_MRST_reset_n = 1'b1;
    repeat (2) @(negedge csi_MCLK_clk);
    checks++;
    if ({avm_read, avm_write} !== 2'b00) begin
      errors++;
      $display("FAIL idle_no_cmd: got rd=%b wr=%b want 00", avm_read, avm_write);
    end
  endtask

  task automatic test_port_a_write();
    int lat = 0;
    int wr_cycles = 0;
    bit done = 0;
    slave_mode = 0; wait_n = 3; use_fixed = 0;
    avs_a_address = 6'd0; avs_a_writedata = 8'h5A; avs_a_write = 1'b1;
    while (!done && lat < 20) begin
      @(negedge csi_MCLK_clk);
      lat++;
      if (avm_write) begin
        wr_cycles++;
        checks++;
        if (avm_address !== 6'd0 || avm_writedata !== 8'h5A) begin
          errors++;
          $display("FAIL a_write_bus: got addr=%h wd=%h want 00 5a", avm_address, avm_writedata);
        end
      end
      checks++;
      if (avm_read !== 1'b0 || avs_b_waitrequest !== 1'b0) begin
        errors++;
        $display("FAIL a_write_side: got avm_read=%b b_wait=%b want 0 0", avm_read, avs_b_waitrequest);
      end
      if (!avs_a_waitrequest) begin
        done = 1;
        avs_a_write = 1'b0;
      end else if (lat == 2) begin
        avs_a_writedata = 8'h00;
      end
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL a_write_latency: got %0d want 5", lat);
    end
    checks++;
    if (wr_cycles !== 4) begin
      errors++;
      $display("FAIL a_write_cmd_cycles: got %0d want 4", wr_cycles);
    end
    @(negedge csi_MCLK_clk);
    checks++;
    if (avs_a_readdata !== 8'h00 || avm_write !== 1'b0) begin
      errors++;
      $display("FAIL a_write_after: got rdata=%h wr=%b want 00 0", avs_a_readdata, avm_write);
    end
  endtask

  task automatic test_port_b_late_read();
    int lat = 0;
    bit done = 0;
    slave_mode = 1; wait_n = 2; use_fixed = 1; fixed_rdata = 8'h37;
    avs_b_address = 6'h0C; avs_b_read = 1'b1;
    while (!done && lat < 20) begin
      @(negedge csi_MCLK_clk);
      lat++;
      if (!avs_b_waitrequest) begin
        done = 1;
        checks++;
        if (avs_b_readdata !== 8'h37) begin
          errors++;
          $display("FAIL b_read_data: got %h want 37", avs_b_readdata);
        end
        avs_b_read = 1'b0;
      end
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL b_read_latency: got %0d want 5", lat);
    end
    checks++;
    if (avs_a_readdata !== 8'h00) begin
      errors++;
      $display("FAIL b_read_a_untouched: got %h want 00", avs_a_readdata);
    end
    use_fixed = 0;
    @(negedge csi_MCLK_clk);
  endtask

  task automatic test_back_to_back();
    logic [5:0] gaddr [4];
    int a_t [2];
    int b_t [2];
    int n_grant = 0;
    int a_cnt = 0;
    int b_cnt = 0;
    int t = 0;
    logic prev_rd = 1'b0;
    logic a_w, b_w;
    apply_reset();
    slave_mode = 0; wait_n = 0; use_fixed = 0;
    for (int i = 0; i < 4; i++) gaddr[i] = 6'h3F;
    a_t[0] = 0; a_t[1] = 0; b_t[0] = 0; b_t[1] = 0;
    avs_a_address = 6'h11; avs_a_read = 1'b1;
    avs_b_address = 6'h22; avs_b_read = 1'b1;
    while ((a_cnt < 2 || b_cnt < 2) && t < 40) begin
      @(negedge csi_MCLK_clk);
      t++;
      if (avm_read && !prev_rd && n_grant < 4) begin
        gaddr[n_grant] = avm_address;
        n_grant++;
      end
      prev_rd = avm_read;
      a_w = avs_a_waitrequest;
      b_w = avs_b_waitrequest;
      if (avs_a_read && !a_w) begin
        a_t[a_cnt] = t;
        checks++;
        if (avs_a_readdata !== 8'hB1) begin
          errors++;
          $display("FAIL b2b_a_rdata: got %h want b1", avs_a_readdata);
        end
        a_cnt++;
        if (a_cnt == 2) avs_a_read = 1'b0;
      end
      if (avs_b_read && !b_w) begin
        b_t[b_cnt] = t;
        checks++;
        if (avs_b_readdata !== 8'h82) begin
          errors++;
          $display("FAIL b2b_b_rdata: got %h want 82", avs_b_readdata);
        end
        b_cnt++;
        if (b_cnt == 2) avs_b_read = 1'b0;
      end
    end
    checks++;
    if ({gaddr[0], gaddr[1], gaddr[2], gaddr[3]} !== {6'h11, 6'h22, 6'h11, 6'h22}) begin
      errors++;
      $display("FAIL b2b_grant_order: got %h %h %h %h want 11 22 11 22", gaddr[0], gaddr[1], gaddr[2], gaddr[3]);
    end
    checks++;
    if (a_t[0] !== 3 || b_t[0] !== 7 || a_t[1] !== 11 || b_t[1] !== 15) begin
      errors++;
      $display("FAIL b2b_done_times: got a=%0d,%0d b=%0d,%0d want a=3,11 b=7,15", a_t[0], a_t[1], b_t[0], b_t[1]);
    end
    @(negedge csi_MCLK_clk);
  endtask

  task automatic test_timeout();
    int lat = 0;
    int rd_cycles = 0;
    bit done = 0;
    slave_mode = 2; use_fixed = 0;
    avs_a_address = 6'h05; avs_a_read = 1'b1;
    while (!done && lat < 100) begin
      @(negedge csi_MCLK_clk);
      lat++;
      if (avm_read) rd_cycles++;
      if (lat == 10) begin
        checks++;
        if (coe_timeout !== 1'b0) begin
          errors++;
          $display("FAIL to_early_flag: got %b want 0", coe_timeout);
        end
      end
      if (!avs_a_waitrequest) begin
        done = 1;
        checks++;
        if (avs_a_readdata !== 8'hFF || coe_timeout !== 1'b1) begin
          errors++;
          $display("FAIL to_done: got rdata=%h to=%b want ff 1", avs_a_readdata, coe_timeout);
        end
        avs_a_read = 1'b0;
        coe_timeout_clr = 1'b0;
      end else if (lat == 64) begin
        coe_timeout_clr = 1'b1;
      end
    end
    coe_timeout_clr = 1'b0;
    checks++;
    if (lat !== 65 || rd_cycles !== 64) begin
      errors++;
      $display("FAIL to_latency: got lat=%0d rd_cycles=%0d want 65 64", lat, rd_cycles);
    end
    repeat (2) @(negedge csi_MCLK_clk);
    checks++;
    if (coe_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: got %b want 1", coe_timeout);
    end
    coe_timeout_clr = 1'b1;
    @(negedge csi_MCLK_clk);
    coe_timeout_clr = 1'b0;
    checks++;
    if (coe_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: got %b want 0", coe_timeout);
    end
    slave_mode = 0; wait_n = 0;
  endtask

  task automatic test_reset_mid_access();
    int lat = 0;
    bit done = 0;
    slave_mode = 0; wait_n = 3; use_fixed = 0;
    avs_a_address = 6'h2A; avs_a_read = 1'b1;
    @(negedge csi_MCLK_clk);
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 6'h2A) begin
      errors++;
      $display("FAIL rst_mid_pre: got rd=%b addr=%h want 1 2a", avm_read, avm_address);
    end
    @(negedge csi_MCLK_clk);
    rsi_MRST_reset_n = 1'b0;
    #1;
    checks++;
    if ({avm_read, avm_write, avm_address, avs_a_readdata, coe_timeout} !== 17'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got rd=%b wr=%b addr=%h rdata=%h to=%b want all 0", avm_read, avm_write, avm_address, avs_a_readdata, coe_timeout);
    end
    checks++;
    if (avs_a_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_stall: got %b want 1", avs_a_waitrequest);
    end
    @(negedge csi_MCLK_clk);
    rsi_MRST_reset_n = 1'b1;
    while (!done && lat < 20) begin
      @(negedge csi_MCLK_clk);
      lat++;
      if (avm_read && avm_address !== 6'h2A) begin
        checks++;
        errors++;
        $display("FAIL rst_mid_addr: got %h want 2a", avm_address);
      end
      if (!avs_a_waitrequest) begin
        done = 1;
        checks++;
        if (avs_a_readdata !== 8'h8A) begin
          errors++;
          $display("FAIL rst_mid_rdata: got %h want 8a", avs_a_readdata);
        end
        avs_a_read = 1'b0;
      end
    end
    checks++;
    if (lat !== 5) begin
      errors++;
      $display("FAIL rst_mid_latency: got %0d want 5", lat);
    end
    @(negedge csi_MCLK_clk);
  endtask

  initial begin
    test_reset();
    test_port_a_write();
    test_port_b_late_read();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avalon_rw8_arbiter.md
Name: avalon_rw8_arbiter

Overview:
- Two-master to one-slave arbiter for the 8-bit Avalon-MM register slaves with waitrequest used across the design, such as the 6-bit-address RW8 test and config slaves.
- Port A is the MCU bridge and port B is the on-chip sequencer/DMA. Both share one downstream slave.
- Arbitration is round-robin, one transfer in flight at a time.
- Address, data and command are registered toward the slave.
- The arbiter ignores early waitrequest during a settle window and enforces a timeout.

Parameters:
- SETTLE, 2: minimum cycles avm_read/avm_write are held before a low avm_waitrequest may complete the transfer. Covers slaves whose waitrequest is registered one cycle late.
- TIMEOUT, 64: maximum cycles in ACCESS before forced completion. Must be > SETTLE and ≤ 255.
- TO_DATA, 8'hFF: readdata returned on a timed-out read.

Ports:
- csi_MCLK_clk  in  1  system clock; the single clock.
- rsi_MRST_reset_n  in  1  asynchronous, active-low reset.
- avs_a_address  in  6  port A address.
- avs_a_writedata  in  8  port A write data.
- avs_a_readdata  out  8  port A read data, registered.
- avs_a_write / avs_a_read  in  1  port A commands.
- avs_a_waitrequest  out  1  port A stall.
- avs_b_address, avs_b_writedata, avs_b_readdata, avs_b_write, avs_b_read, avs_b_waitrequest: same as port A, for port B.
- avm_address  out  6  registered address to slave.
- avm_writedata  out  8  registered write data to slave.
- avm_readdata  in  8  slave read data.
- avm_write / avm_read  out  1  registered commands to slave.
- avm_waitrequest  in  1  slave stall.
- coe_timeout  out  1  sticky timeout flag.
- coe_timeout_clr  in  1  synchronous clear of coe_timeout.

Behaviour:
- Reset values: state=IDLE, last=B (so A wins the first tie), avm_* = 0, both readdata = 0, done pulses = 0, cnt = 0, coe_timeout = 0.
- avs_x_waitrequest = (avs_x_read | avs_x_write) & ~done_x. This is combinational on the request. A port is stalled from its first request cycle until its done cycle.
- Request: req_x = avs_x_read | avs_x_write. If read and write are both high, treat as a read.

FSM:
- IDLE:
  - If req_a & req_b, grant the port != last. Otherwise grant the single requester.
  - On grant, latch address, writedata and command into avm_*, set sel and last, cnt = 0, go to ACCESS.
  - avm_read/avm_write rise the cycle after grant.
- ACCESS:
  - cnt increments each cycle, saturating at TIMEOUT.
  - Complete when cnt ≥ SETTLE-1 and avm_waitrequest = 0.
  - On completion: capture avm_readdata into the selected port's readdata (reads only; writes leave readdata unchanged), drop avm_read/avm_write, raise done_sel, go to DONE.
  - Timeout when cnt == TIMEOUT-1 and the transfer has not completed. Handle as completion, but load readdata with TO_DATA and set coe_timeout.
- DONE:
  - done_sel is high for exactly this one cycle, so the master sees waitrequest low for one cycle with readdata already valid.
  - Clear done, go to IDLE.
  - A request still asserted in the same cycle is a new transfer and is arbitrated in IDLE on the next cycle.

Latency and fairness:
- Minimum latency is 1 (IDLE) + SETTLE (ACCESS) + 1 (DONE) = 4 cycles at SETTLE=2, from request to waitrequest low.
- Back-to-back requests from both ports strictly alternate A,B,A,B.
- A lone requester is granted every time regardless of last.

Boundary conditions:
- A request deasserted mid-ACCESS is a master protocol violation. The transfer still completes to the slave, and the done pulse is issued and ignored.
- coe_timeout_clr in the same cycle as a new timeout: set wins.
- Asynchronous reset mid-ACCESS: avm_read/avm_write drop immediately and the FSM returns to IDLE. The upstream master stays stalled while its request remains and is re-arbitrated after reset release.
- Address and writedata are sampled only at grant. Changes during the stall are ignored.

Decomposition:
- Shared package/include: state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), the port-select constant (A=0, B=1), and the default TO_DATA value.
- Sub-module: avalon_rr_arb2, a 2-request round-robin grant with a last-grant register, reusable by other shared slaves.
- Everything else lives in the top block.

Test Plan:
- Port A write only: A writes 8'h5A to address 0, slave waitrequest high for 3 cycles after avm_write rises, then low. Expect one avm_write burst with address 0 and data 5A, then avs_a_waitrequest low for exactly one cycle; B untouched.
- Port B read with a late-waitrequest slave: the slave asserts waitrequest only from the second command cycle and returns 8'h37. Expect no completion before cnt ≥ SETTLE-1; avs_b_readdata = 37 during B's done cycle.
- Simultaneous requests: A and B both read at the same cycle out of reset, each twice back-to-back. Expect grants in order A,B,A,B and avm_address matching each port's address.
- Timeout: slave holds waitrequest high permanently and A reads. Expect completion at TIMEOUT=64 cycles, avs_a_readdata = FF, coe_timeout = 1. Pulse coe_timeout_clr and expect coe_timeout = 0.
- Reset mid-operation: assert rsi_MRST_reset_n low during ACCESS. Expect avm_read = 0 immediately and all outputs at reset values. Release reset with the request held: the transfer re-runs and completes normally.
